// File: rtl/tomasula_types.sv
// rtl/tomasula_types.sv - shared CDB request/broadcast types and ROB sizing constants
package tomasula_types;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    data;
        logic                 br_taken;
    } cdb_req_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    data;
        logic [ROB_DEPTH-1:0] set_rob_valid;
        logic                 update_br;
        logic [ROB_IDX_W-1:0] br_entry;
        logic                 br_taken;
    } cdb_bcast_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter; CDB_ARB_BR_PRIO_EN gives the branch unit fixed priority
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]  req_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic                          req_br_taken,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush_in_prog,
    input  logic [ROB_DEPTH-1:0]          allocated_rob,
    input  logic [ROB_DEPTH-1:0]          status_rob_valid,
    output logic                          cdb_valid,
    output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
    output logic [DATA_W-1:0]             cdb_data,
    output logic [ROB_DEPTH-1:0]          set_rob_valid,
    output logic                          update_br,
    output logic [ROB_IDX_W-1:0]          br_entry,
    output logic                          br_taken,
    output logic                          err_dup
);

    cdb_req_t           reqs [NUM_REQ];
    cdb_req_t           win;
    cdb_bcast_t         bc;
    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] kill, dup, live, arb_req;
    logic [NUM_REQ-1:0] rr_req, rr_gnt, gnt;
    logic [PW-1:0]      rr_idx, gnt_idx;
    logic               rr_any, gnt_any, ptr_adv;

    // Killed entries were freed by a flush; duplicates are drained but flagged.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].valid    = req_valid[i];
            reqs[i].rob_idx  = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            reqs[i].data     = req_data[i*DATA_W +: DATA_W];
            reqs[i].br_taken = (i == 0) ? req_br_taken : 1'b0;
            kill[i] = reqs[i].valid & ~allocated_rob[reqs[i].rob_idx];
            dup[i]  = reqs[i].valid &  allocated_rob[reqs[i].rob_idx] &  status_rob_valid[reqs[i].rob_idx];
            live[i] = reqs[i].valid &  allocated_rob[reqs[i].rob_idx] & ~status_rob_valid[reqs[i].rob_idx];
        end
    end

    assign arb_req = flush_in_prog ? '0 : live;

`ifdef CDB_ARB_BR_PRIO_EN
    assign rr_req = arb_req & ~NUM_REQ'(1);

    always_comb begin
        if (arb_req[0]) begin
            gnt     = NUM_REQ'(1);
            gnt_idx = '0;
            gnt_any = 1'b1;
        end else begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end
    end

    // Branch wins do not move the pointer so the other units keep their turn order.
    assign ptr_adv = rr_any & ~arb_req[0];
`else
    assign rr_req  = arb_req;
    assign gnt     = rr_gnt;
    assign gnt_idx = rr_idx;
    assign gnt_any = rr_any;
    assign ptr_adv = rr_any;
`endif

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req     (rr_req),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    assign win       = reqs[gnt_idx];
    assign req_ready = kill | dup | gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc      <= '0;
            rr_ptr  <= '0;
            err_dup <= 1'b0;
        end else begin
            bc.valid         <= gnt_any;
            bc.set_rob_valid <= gnt_any ? (ROB_DEPTH'(1) << win.rob_idx) : '0;
            bc.update_br     <= gnt[0];
            if (gnt_any) begin
                bc.rob_idx <= win.rob_idx;
                bc.data    <= win.data;
            end
            if (gnt[0]) begin
                bc.br_entry <= win.rob_idx;
                bc.br_taken <= win.br_taken;
            end
            if (ptr_adv) begin
                rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            end
            if (|dup) begin
                err_dup <= 1'b1;
            end
        end
    end

    assign cdb_valid     = bc.valid;
    assign cdb_rob_idx   = bc.rob_idx;
    assign cdb_data      = bc.data;
    assign set_rob_valid = bc.set_rob_valid;
    assign update_br     = bc.update_br;
    assign br_entry      = bc.br_entry;
    assign br_taken      = bc.br_taken;

endmodule
